// File: rtl/id_operand_scoreboard_pkg.sv
// Shared definitions for the ID-stage operand/scoreboard unit: default widths,
// control-word layout and the hard-zero register index.
package id_operand_scoreboard_pkg;

  localparam int AW_DEF   = 5;
  localparam int DW_DEF   = 32;
  localparam int ALUOP_W  = 8;
  localparam int ALUSEL_W = 3;
  localparam int CW_DEF   = ALUOP_W + ALUSEL_W;
  localparam int REG_ZERO = 0;

  // Control word as handed to EX: aluop in the upper bits, alusel below.
  typedef struct packed {
    logic [ALUOP_W-1:0]  aluop;
    logic [ALUSEL_W-1:0] alusel;
  } ctl_t;

endpackage

// File: rtl/id_operand_scoreboard_fwd_mux.sv
// One operand read port: priority forward select (youngest stage wins) and the
// port's interlock term (load-use on the selected stage, or pending long write).
module id_fwd_mux
  import id_operand_scoreboard_pkg::*;
#(
  parameter int NFWD = 2,
  parameter int AW   = AW_DEF,
  parameter int DW   = DW_DEF
) (
  input  logic                 re,
  input  logic [AW-1:0]        raddr,
  input  logic [DW-1:0]        imm,
  input  logic [DW-1:0]        rf_rdata,
  input  logic [NFWD-1:0]      fwd_we,
  input  logic [NFWD*AW-1:0]   fwd_waddr,
  input  logic [NFWD*DW-1:0]   fwd_wdata,
  input  logic [NFWD-1:0]      fwd_rdy,
  input  logic [(1<<AW)-1:0]   pending,
  output logic [DW-1:0]        opv,
  output logic                 hazard
);

  logic          nonzero;
  logic          hit;
  logic          hit_rdy;
  logic [DW-1:0] hit_data;

  assign nonzero = (raddr != AW'(REG_ZERO));

  // Scan oldest to youngest so the lowest-index matching stage is the one kept.
  always_comb begin
    hit      = 1'b0;
    hit_rdy  = 1'b1;
    hit_data = '0;
    for (int s = NFWD - 1; s >= 0; s--) begin
      if (fwd_we[s] && nonzero && (fwd_waddr[s*AW +: AW] == raddr)) begin
        hit      = 1'b1;
        hit_rdy  = fwd_rdy[s];
        hit_data = fwd_wdata[s*DW +: DW];
      end
    end
  end

  always_comb begin
    opv = rf_rdata;
    if (!re) begin
      opv = imm;
    end else if (!nonzero) begin
      opv = '0;
    end else if (hit) begin
      opv = hit_data;
    end
    hazard = re && nonzero && ((hit && !hit_rdy) || pending[raddr]);
  end

endmodule

// File: rtl/id_operand_scoreboard.sv
// ID-stage operand unit: per-port operand resolution, long-latency write
// scoreboard with RAW/WAW interlocks, and a valid/ready ID/EX output latch.
module id_operand_scoreboard
  import id_operand_scoreboard_pkg::*;
#(
  parameter int NRP  = 2,
  parameter int NFWD = 2,
  parameter int AW   = AW_DEF,
  parameter int DW   = DW_DEF,
  parameter int CW   = CW_DEF
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [NRP-1:0]       in_re,
  input  logic [NRP*AW-1:0]    in_raddr,
  input  logic [NRP*DW-1:0]    in_imm,
  input  logic                 in_we,
  input  logic [AW-1:0]        in_waddr,
  input  logic                 in_long,
  input  logic [CW-1:0]        in_ctl,
  output logic [NRP*AW-1:0]    rf_raddr,
  input  logic [NRP*DW-1:0]    rf_rdata,
  input  logic [NFWD-1:0]      fwd_we,
  input  logic [NFWD*AW-1:0]   fwd_waddr,
  input  logic [NFWD*DW-1:0]   fwd_wdata,
  input  logic [NFWD-1:0]      fwd_rdy,
  input  logic                 done_we,
  input  logic [AW-1:0]        done_addr,
  input  logic                 flush,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [NRP*DW-1:0]    out_opv,
  output logic                 out_we,
  output logic [AW-1:0]        out_waddr,
  output logic [CW-1:0]        out_ctl,
  output logic                 stallreq
);

  localparam int NREG = 1 << AW;

  logic [NREG-1:0]     pending;
  logic [NREG-1:0]     pending_next;
  logic [NRP*DW-1:0]   opv_res;
  logic [NRP-1:0]      port_hazard;
  logic                waw;
  logic                hazard;
  logic                issue;

  assign rf_raddr = in_raddr;

  for (genvar p = 0; p < NRP; p++) begin : g_port
    id_fwd_mux #(
      .NFWD (NFWD),
      .AW   (AW),
      .DW   (DW)
    ) u_fwd_mux (
      .re        (in_re[p]),
      .raddr     (in_raddr[p*AW +: AW]),
      .imm       (in_imm[p*DW +: DW]),
      .rf_rdata  (rf_rdata[p*DW +: DW]),
      .fwd_we    (fwd_we),
      .fwd_waddr (fwd_waddr),
      .fwd_wdata (fwd_wdata),
      .fwd_rdy   (fwd_rdy),
      .pending   (pending),
      .opv       (opv_res[p*DW +: DW]),
      .hazard    (port_hazard[p])
    );
  end

  assign waw      = in_we && (in_waddr != AW'(REG_ZERO)) && pending[in_waddr];
  assign hazard   = (|port_hazard) || waw;
  assign stallreq = in_valid && hazard;
  assign issue    = in_valid && !hazard && !flush && (!out_valid || out_ready);
  assign in_ready = issue;

  // Set is applied after clear so a same-cycle retire/reissue stays pending.
  always_comb begin
    pending_next = pending;
    if (done_we) begin
      pending_next[done_addr] = 1'b0;
    end
    if (issue && in_we && in_long && (in_waddr != AW'(REG_ZERO))) begin
      pending_next[in_waddr] = 1'b1;
    end
    pending_next[REG_ZERO] = 1'b0;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      pending <= '0;
    end else begin
      pending <= pending_next;
    end
  end

  // Data registers only load on issue, so a stalled or flushed latch keeps its payload.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      out_valid <= 1'b0;
      out_opv   <= '0;
      out_we    <= 1'b0;
      out_waddr <= '0;
      out_ctl   <= '0;
    end else if (flush) begin
      out_valid <= 1'b0;
    end else if (issue) begin
      out_valid <= 1'b1;
      out_opv   <= opv_res;
      out_we    <= in_we;
      out_waddr <= in_waddr;
      out_ctl   <= in_ctl;
    end else if (out_ready) begin
      out_valid <= 1'b0;
    end
  end

endmodule
